music_sequencer: RTL and testbench
==================================

# music_sequencer

Plays a song from a synchronous ROM by driving the 8-bit note code into the square-wave generator. Each ROM entry holds a note code and a duration in time units. The block steps through the entries, holds each note for its duration, and inserts a short silent gap between notes. It sits between the game control logic (start/stop/loop) and the tone generator, and is the only writer of the generator's note input.

## Interface
Parameters:
- TICKS_PER_UNIT, default 6_250_000: clock cycles per duration unit (one sixteenth note at 120 BPM on the 50 MHz clock). Must be ≥1.
- GAP_TICKS, default 250_000: silent cycles after each note. 0 means no gap.
- ADDR_W, default 8: song ROM address width.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins playback at address 0
- stop  in  1  one-cycle pulse; aborts playback
- loop_en  in  1  sampled at the end marker; 1 means restart at address 0
- rom_addr  out  ADDR_W  song ROM address (registered)
- rom_data  in  16  {note[15:8], dur[7:0]}; valid one cycle after rom_addr
- note  out  8  note code to the tone generator (registered); 0 means silence
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the song ends without looping

## Operation
- States and transitions:
  - IDLE: on start (and no stop), go to FETCH.
  - FETCH: go to LOAD.
  - LOAD: if dur≠0, go to PLAY. If dur==0 and loop_en=1, go to FETCH. If dur==0 and loop_en=0, go to IDLE.
  - PLAY: go to GAP when the hold expires (to FETCH if GAP_TICKS=0).
  - GAP: go to FETCH when the gap expires.
- Entry decode:
  - dur==0 is the end marker. Its note field is ignored.
  - note==0 with dur≠0 is a rest: PLAY runs with note held at 0.
- Hold time:
  - PLAY lasts exactly dur×TICKS_PER_UNIT cycles.
  - Implemented as a unit-tick counter (0…TICKS_PER_UNIT−1) plus an 8-bit unit down-counter loaded with dur.
- note:
  - Equals the entry note for every PLAY cycle.
  - Is 0 in IDLE, FETCH, LOAD and GAP.
- rom_addr:
  - Increments by 1 on each GAP→FETCH (or PLAY→FETCH) transition.
  - Wraps from 2^ADDR_W−1 to 0 regardless of loop_en.
  - Set to 0 on start, on the loop restart, on stop, and on reset.
- Priority and collisions:
  - stop beats start in the same cycle: the block goes to or stays in IDLE.
  - start while busy is ignored.
  - stop in any busy state: IDLE on the next cycle, note=0, rom_addr=0, no done pulse.
- done:
  - Asserted only on the cycle the state enters IDLE from LOAD because of the end marker.
  - Not asserted on stop or reset.

## Timing
- Reset values: state=IDLE, note=0, rom_addr=0, busy=0, done=0; both counters cleared.
- Reset mid-operation takes effect on the next edge and overrides start and stop.
- Start latency:
  - Cycle t: start=1.
  - t+1: FETCH, rom_addr=0, busy=1.
  - t+2: LOAD, rom_data captured.
  - t+3: first PLAY cycle, note valid.
- Per-entry period: dur×TICKS_PER_UNIT + GAP_TICKS + 2 cycles (FETCH and LOAD are silent).
- End of song: after LOAD sees dur==0, the next cycle is IDLE with done=1 (no loop), or FETCH at address 0 (loop).
- Counter widths: the unit counter is $clog2(TICKS_PER_UNIT+1) bits; the gap counter is $clog2(GAP_TICKS+1) bits. No overflow is possible for legal parameters.

## Configuration
- MUSIC_SEQ_PAUSE_EN:
  - When defined, adds input `pause` (1 bit).
  - While pause=1 in PLAY or GAP: all counters freeze, note is forced to 0, and state is held.
  - When pause is released, playback resumes the same note with its remaining hold time.
  - pause is ignored in IDLE, FETCH and LOAD. stop and reset still override it.
  - When the macro is undefined, the port does not exist and behaviour is as described above.

## Structure
- Shared package `music_pkg` holds:
  - the state enum (IDLE, FETCH, LOAD, PLAY, GAP);
  - a packed struct `song_entry_t` {note[7:0], dur[7:0]};
  - the constant `NOTE_REST = 8'd0`.
- One sub-module, `unit_timer`: the unit-tick counter plus the unit down-counter.
  - Inputs: load/dur, enable.
  - Output: an `expired` pulse.
  - The gap counter is also built from `unit_timer`, loaded with dur=1.

## Test plan
Bench parameters: TICKS_PER_UNIT=4, GAP_TICKS=2; the ROM model has 1-cycle latency.
- ROM {0x3C,2},{0x40,1},{0x00,0}, loop_en=0, start at t=0 → note=0x3C over t=3..10, 0 over t=11..14, 0x40 over t=15..18; done=1 at t=23; busy=0 afterwards.
- Same ROM with loop_en=1 → after the end marker, rom_addr returns to 0 and 0x3C replays; done never pulses.
- stop asserted mid-PLAY at cycle k → at k+1: IDLE, note=0, rom_addr=0, done=0.
- start and stop in the same cycle from IDLE → the block stays IDLE with busy=0; start during PLAY → timing unchanged.
- Rest entry {0x00,3} → note=0 for 12 cycles with busy=1; reset asserted mid-GAP → all outputs at reset values on the next cycle.
- With MUSIC_SEQ_PAUSE_EN: pause held 5 cycles mid-note → note=0 during the pause, and the note's total active cycles still equal dur×4.

Source files
------------

// File: rtl/music_sequencer_pkg.sv
// music_pkg: shared types for the music sequencer.
//   state_t      - sequencer FSM states
//   song_entry_t - one song ROM word, {note[7:0], dur[7:0]}
//   NOTE_REST    - note code that silences the tone generator
package music_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      PLAY  = 3'd3,
      GAP   = 3'd4
   } state_t;

   typedef struct packed {
      logic [7:0] note;
      logic [7:0] dur;
   } song_entry_t;

   localparam logic [7:0] NOTE_REST = 8'd0;

endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: control, song ROM and tone-generator signals of the
// music sequencer.
//   master modport - game control / ROM side (drives start, stop, loop_en,
//                    rom_data and, when MUSIC_SEQ_PAUSE_EN is defined, pause)
//   slave modport  - the sequencer itself
// Handshake: start and stop are single-cycle pulses with no acknowledge;
// rom_data is valid exactly one cycle after rom_addr is presented and is
// consumed only in the LOAD state. Optional feature macro: MUSIC_SEQ_PAUSE_EN.
interface music_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              stop;
   logic              loop_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data;
   logic [7:0]        note;
   logic              busy;
   logic              done;
`ifdef MUSIC_SEQ_PAUSE_EN
   logic              pause;

   modport master (output start, stop, loop_en, rom_data, pause,
                   input  rom_addr, note, busy, done);
   modport slave  (input  start, stop, loop_en, rom_data, pause,
                   output rom_addr, note, busy, done);
`else
   modport master (output start, stop, loop_en, rom_data,
                   input  rom_addr, note, busy, done);
   modport slave  (input  start, stop, loop_en, rom_data,
                   output rom_addr, note, busy, done);
`endif
endinterface

// File: rtl/music_sequencer_unit_timer.sv
// unit_timer: counts dur units of TICKS clock cycles each.
//   clock, reset - system clock, synchronous active-high reset
//   load, dur    - (re)start the timer for dur units
//   enable       - advance the timer this cycle (low = frozen)
//   expired      - high on the last enabled cycle of the programmed time
module unit_timer #(
   parameter int unsigned TICKS = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] dur,
   input  logic       enable,
   output logic       expired
);
   localparam int TW = $clog2(TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

   logic [TW-1:0] tick_cnt;
   logic [7:0]    unit_cnt;
   logic          last_tick;

   assign last_tick = (tick_cnt == TICK_LAST);
   // Combinational so the owner can leave its state on the final cycle,
   // making the timed interval exactly dur*TICKS enabled cycles.
   assign expired   = enable && (unit_cnt == 8'd1) && last_tick;

   always_ff @(posedge clock) begin
      if (reset) begin
         tick_cnt <= '0;
         unit_cnt <= '0;
      end else if (load) begin
         tick_cnt <= '0;
         unit_cnt <= dur;
      end else if (enable && (unit_cnt != 8'd0)) begin
         if (last_tick) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt - 8'd1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: steps through a song ROM, holding each note for
// dur*TICKS_PER_UNIT cycles followed by GAP_TICKS silent cycles.
//   clock, reset - system clock, synchronous active-high reset
//   bus          - music_sequencer_if.slave (start/stop/loop_en control,
//                  rom_addr/rom_data song ROM, note/busy/done outputs)
//   state_dbg    - current FSM state
// Optional feature macro MUSIC_SEQ_PAUSE_EN adds bus.pause, which freezes
// PLAY/GAP timing and silences the note while held.
module music_sequencer
   import music_pkg::*;
#(
   parameter int unsigned TICKS_PER_UNIT = 6_250_000,
   parameter int unsigned GAP_TICKS      = 250_000,
   parameter int unsigned ADDR_W         = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   music_sequencer_if.slave       bus,
   output state_t                 state_dbg
);
   // A zero gap still instantiates a (never enabled) 1-tick timer.
   localparam int unsigned GAP_UNIT = (GAP_TICKS == 0) ? 1 : GAP_TICKS;

   state_t            state, state_next;
   song_entry_t       entry;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        note_q;
   logic              done_q;
   logic              pause_act;
   logic              play_load, play_en, play_exp;
   logic              gap_en, gap_exp;

   assign entry = song_entry_t'(bus.rom_data);

`ifdef MUSIC_SEQ_PAUSE_EN
   assign pause_act = bus.pause;
`else
   assign pause_act = 1'b0;
`endif

   assign play_load = (state == LOAD);
   assign play_en   = (state == PLAY) && !pause_act;
   assign gap_en    = (state == GAP) && !pause_act;

   unit_timer #(.TICKS(TICKS_PER_UNIT)) u_play_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (play_load),
      .dur     (entry.dur),
      .enable  (play_en),
      .expired (play_exp)
   );

   // The gap is a one-unit timer of GAP_UNIT ticks, armed as the note ends.
   unit_timer #(.TICKS(GAP_UNIT)) u_gap_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (play_exp),
      .dur     (8'd1),
      .enable  (gap_en),
      .expired (gap_exp)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (bus.start) state_next = FETCH;
         FETCH: state_next = LOAD;
         LOAD: begin
            if (entry.dur != 8'd0) state_next = PLAY;
            else if (bus.loop_en)  state_next = FETCH;
            else                   state_next = IDLE;
         end
         PLAY:  if (play_exp) state_next = (GAP_TICKS == 0) ? FETCH : GAP;
         GAP:   if (gap_exp)  state_next = FETCH;
         default: state_next = IDLE;
      endcase
      // stop wins over everything except reset, including a same-cycle start.
      if (bus.stop) state_next = IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= '0;
         note_q <= NOTE_REST;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == LOAD) && (entry.dur == 8'd0) && !bus.loop_en && !bus.stop;

         // The note is captured on LOAD->PLAY and held for the whole PLAY.
         if (state_next == PLAY) note_q <= (state == LOAD) ? entry.note : note_q;
         else                    note_q <= NOTE_REST;

         // FETCH entered from PLAY/GAP advances; from IDLE/LOAD it restarts.
         if (bus.stop)                addr_q <= '0;
         else if (state_next == FETCH) begin
            if ((state == PLAY) || (state == GAP)) addr_q <= addr_q + 1'b1;
            else                                   addr_q <= '0;
         end
      end
   end

   assign bus.rom_addr = addr_q;
   assign bus.note     = pause_act ? NOTE_REST : note_q;
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign state_dbg    = state;

endmodule

// File: tb/tb_music_sequencer.sv
module tb_music_sequencer;
   import music_pkg::*;

   typedef struct {
      logic       start;
      logic       stop;
      logic       loop_en;
      state_t     exp_state;
      logic [7:0] exp_note;
      logic [7:0] exp_addr;
      logic       exp_done;
   } vec_t;

   logic   clock;
   logic   reset;
   state_t state_dbg;
   logic [15:0] rom [0:255];
   vec_t   vecs[$];
   int     errors;
   int     checks;

   music_sequencer_if #(.ADDR_W(8)) bus ();

   music_sequencer #(
      .TICKS_PER_UNIT (4),
      .GAP_TICKS      (2),
      .ADDR_W         (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / ROM model ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_rom(logic [15:0] e0, logic [15:0] e1, logic [15:0] e2);
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[0] = e0;
      rom[1] = e1;
      rom[2] = e2;
   endtask

   task automatic do_reset();
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.loop_en = 1'b0;
`ifdef MUSIC_SEQ_PAUSE_EN
      bus.pause   = 1'b0;
`endif
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic add(int n, logic st, logic sp, logic lp, state_t s,
                      logic [7:0] nt, logic [7:0] ad, logic dn);
      vec_t v;
      v.start = st; v.stop = sp; v.loop_en = lp;
      v.exp_state = s; v.exp_note = nt; v.exp_addr = ad; v.exp_done = dn;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   // Each vector's inputs are held for one cycle; the outputs after the
   // following edge must match its expectations.
   task automatic run_vecs(string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         bus.start   = vecs[i].start;
         bus.stop    = vecs[i].stop;
         bus.loop_en = vecs[i].loop_en;
         tick();
         check($sformatf("%s c%0d state", tag, i + 1), 32'(state_dbg), 32'(vecs[i].exp_state));
         check($sformatf("%s c%0d note", tag, i + 1), 32'(bus.note), 32'(vecs[i].exp_note));
         check($sformatf("%s c%0d addr", tag, i + 1), 32'(bus.rom_addr), 32'(vecs[i].exp_addr));
         check($sformatf("%s c%0d busy", tag, i + 1), 32'(bus.busy),
               32'(vecs[i].exp_state != IDLE));
         check($sformatf("%s c%0d done", tag, i + 1), 32'(bus.done), 32'(vecs[i].exp_done));
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      vecs.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      errors = 0;
      checks = 0;
      load_rom(16'h3C02, 16'h4001, 16'h0000);
      do_reset();

      check("reset state", 32'(state_dbg), 32'(IDLE));
      check("reset note", 32'(bus.note), 32'h0);
      check("reset addr", 32'(bus.rom_addr), 32'h0);
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset done", 32'(bus.done), 32'h0);

      // Song without loop; a start pulse mid-PLAY must be ignored.
      add(1, 1, 0, 0, FETCH, 8'h00, 8'd0, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd0, 0);
      add(2, 0, 0, 0, PLAY,  8'h3C, 8'd0, 0);
      add(1, 1, 0, 0, PLAY,  8'h3C, 8'd0, 0);
      add(5, 0, 0, 0, PLAY,  8'h3C, 8'd0, 0);
      add(2, 0, 0, 0, GAP,   8'h00, 8'd0, 0);
      add(1, 0, 0, 0, FETCH, 8'h00, 8'd1, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd1, 0);
      add(4, 0, 0, 0, PLAY,  8'h40, 8'd1, 0);
      add(2, 0, 0, 0, GAP,   8'h00, 8'd1, 0);
      add(1, 0, 0, 0, FETCH, 8'h00, 8'd2, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd2, 0);
      add(1, 0, 0, 0, IDLE,  8'h00, 8'd2, 1);
      add(2, 0, 0, 0, IDLE,  8'h00, 8'd2, 0);
      run_vecs("song");

      // Same song looping; end marker restarts at address 0, then stop in FETCH.
      do_reset();
      add(1, 1, 0, 1, FETCH, 8'h00, 8'd0, 0);
      add(1, 0, 0, 1, LOAD,  8'h00, 8'd0, 0);
      add(8, 0, 0, 1, PLAY,  8'h3C, 8'd0, 0);
      add(2, 0, 0, 1, GAP,   8'h00, 8'd0, 0);
      add(1, 0, 0, 1, FETCH, 8'h00, 8'd1, 0);
      add(1, 0, 0, 1, LOAD,  8'h00, 8'd1, 0);
      add(4, 0, 0, 1, PLAY,  8'h40, 8'd1, 0);
      add(2, 0, 0, 1, GAP,   8'h00, 8'd1, 0);
      add(1, 0, 0, 1, FETCH, 8'h00, 8'd2, 0);
      add(1, 0, 0, 1, LOAD,  8'h00, 8'd2, 0);
      add(1, 0, 0, 1, FETCH, 8'h00, 8'd0, 0);
      add(1, 0, 0, 1, LOAD,  8'h00, 8'd0, 0);
      add(8, 0, 0, 1, PLAY,  8'h3C, 8'd0, 0);
      add(2, 0, 0, 1, GAP,   8'h00, 8'd0, 0);
      add(1, 0, 0, 1, FETCH, 8'h00, 8'd1, 0);
      add(1, 0, 1, 1, IDLE,  8'h00, 8'd0, 0);
      add(1, 0, 0, 0, IDLE,  8'h00, 8'd0, 0);
      run_vecs("loop");

      // stop in the middle of the second note.
      do_reset();
      add(1, 1, 0, 0, FETCH, 8'h00, 8'd0, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd0, 0);
      add(8, 0, 0, 0, PLAY,  8'h3C, 8'd0, 0);
      add(2, 0, 0, 0, GAP,   8'h00, 8'd0, 0);
      add(1, 0, 0, 0, FETCH, 8'h00, 8'd1, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd1, 0);
      add(2, 0, 0, 0, PLAY,  8'h40, 8'd1, 0);
      add(1, 0, 1, 0, IDLE,  8'h00, 8'd0, 0);
      add(1, 0, 0, 0, IDLE,  8'h00, 8'd0, 0);
      run_vecs("stop");

      // start and stop together from IDLE.
      add(1, 1, 1, 0, IDLE,  8'h00, 8'd0, 0);
      add(1, 0, 0, 0, IDLE,  8'h00, 8'd0, 0);
      run_vecs("collide");

      // Rest entry at address 1, then reset mid-GAP (with start also high).
      load_rom(16'h5001, 16'h0003, 16'h0000);
      do_reset();
      add(1, 1, 0, 0, FETCH, 8'h00, 8'd0, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd0, 0);
      add(4, 0, 0, 0, PLAY,  8'h50, 8'd0, 0);
      add(2, 0, 0, 0, GAP,   8'h00, 8'd0, 0);
      add(1, 0, 0, 0, FETCH, 8'h00, 8'd1, 0);
      add(1, 0, 0, 0, LOAD,  8'h00, 8'd1, 0);
      add(12, 0, 0, 0, PLAY, 8'h00, 8'd1, 0);
      add(1, 0, 0, 0, GAP,   8'h00, 8'd1, 0);
      run_vecs("rest");
      reset     = 1'b1;
      bus.start = 1'b1;
      tick();
      check("midgap reset state", 32'(state_dbg), 32'(IDLE));
      check("midgap reset note", 32'(bus.note), 32'h0);
      check("midgap reset addr", 32'(bus.rom_addr), 32'h0);
      check("midgap reset busy", 32'(bus.busy), 32'h0);
      check("midgap reset done", 32'(bus.done), 32'h0);
      reset     = 1'b0;
      bus.start = 1'b0;

`ifdef MUSIC_SEQ_PAUSE_EN
      // Pause for cycles 5..9 of the first note: 8 audible cycles, PLAY
      // stretched by 5, so the gap begins at cycle 16 instead of 11.
      begin
         int active;
         int gap_cycle;
         int paused_bad;
         active = 0;
         gap_cycle = -1;
         paused_bad = 0;
         load_rom(16'h3C02, 16'h4001, 16'h0000);
         do_reset();
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         tick();
         for (int cyc = 3; cyc < 40; cyc++) begin
            tick();
            bus.pause = (cyc >= 5) && (cyc <= 9);
            #1;
            if (state_dbg == GAP) begin
               gap_cycle = cyc;
               break;
            end
            if (bus.note == 8'h3C) active++;
            if (bus.pause && (bus.note != 8'h00)) paused_bad++;
         end
         bus.pause = 1'b0;
         check("pause active cycles", 32'(active), 32'd8);
         check("pause silent", 32'(paused_bad), 32'd0);
         check("pause gap cycle", 32'(gap_cycle), 32'd16);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
